// File: rtl/alu_result_decoder.sv
// alu_result_decoder
//   Accepts a 4-bit two's-complement ALU result (plus overflow flag) over a
//   valid/ready handshake, converts it to sign-magnitude and drives two
//   active-low seven-segment digits. Each result is held for HOLD_CYCLES
//   before the next is accepted; an overflowed result shows a blinking "E".
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake
//   in_res[3:0]         two's-complement result
//   in_overflow         ALU overflow flag
//   sign, mag[3:0], err registered conversion result and captured overflow
//   disp_valid          one-cycle pulse when new outputs land
//   seg_sign[7:0]       active-low {dp,g,f,e,d,c,b,a}, sign digit
//   seg_mag[7:0]        active-low {dp,g,f,e,d,c,b,a}, magnitude digit
module alu_result_decoder #(
   parameter int HOLD_CYCLES = 4,
   parameter int BLINK_HALF  = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_res,
   input  logic       in_overflow,
   output logic       sign,
   output logic [3:0] mag,
   output logic       err,
   output logic       disp_valid,
   output logic [7:0] seg_sign,
   output logic [7:0] seg_mag
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CONV = 2'd1;
   localparam logic [1:0] SHOW = 2'd2;

   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int BW = (BLINK_HALF  > 1) ? $clog2(BLINK_HALF)  : 1;

   localparam logic [7:0] SEG_MINUS = 8'hBF;
   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_E     = 8'h86;

   logic [1:0]    state;
   logic [3:0]    res_q;
   logic          ovf_q;
   logic [HW-1:0] hold_cnt;
   logic [BW-1:0] blink_cnt;

   logic          cv_sign;
   logic [3:0]    cv_mag;

   function automatic logic [7:0] digit(input logic [3:0] d);
      case (d)
         4'd0:    digit = 8'hC0;
         4'd1:    digit = 8'hF9;
         4'd2:    digit = 8'hA4;
         4'd3:    digit = 8'hB0;
         4'd4:    digit = 8'h99;
         4'd5:    digit = 8'h92;
         4'd6:    digit = 8'h82;
         4'd7:    digit = 8'hF8;
         4'd8:    digit = 8'h80;
         default: digit = SEG_BLANK;
      endcase
   endfunction

   assign in_ready = (state == IDLE);

   // -8 negates to itself in 4 bits, which reads back as magnitude 8.
   assign cv_sign = res_q[3];
   assign cv_mag  = cv_sign ? (~res_q + 4'd1) : res_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         res_q      <= 4'd0;
         ovf_q      <= 1'b0;
         hold_cnt   <= '0;
         blink_cnt  <= '0;
         sign       <= 1'b0;
         mag        <= 4'd0;
         err        <= 1'b0;
         disp_valid <= 1'b0;
         seg_sign   <= SEG_BLANK;
         seg_mag    <= 8'hC0;
      end else begin
         disp_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (in_valid) begin
                  res_q <= in_res;
                  ovf_q <= in_overflow;
                  state <= CONV;
               end
            end
            CONV: begin
               state      <= SHOW;
               hold_cnt   <= '0;
               blink_cnt  <= '0;
               sign       <= cv_sign;
               mag        <= cv_mag;
               err        <= ovf_q;
               disp_valid <= 1'b1;
               seg_sign   <= (cv_sign && !ovf_q) ? SEG_MINUS : SEG_BLANK;
               seg_mag    <= ovf_q ? SEG_E : digit(cv_mag);
            end
            SHOW: begin
               if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                  hold_cnt <= '0;
                  state    <= IDLE;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase

         // Blink free-runs through SHOW and IDLE; the CONV load above
         // restarts the phase on every new result.
         if (err && state != CONV) begin
            if (blink_cnt == BW'(BLINK_HALF - 1)) begin
               blink_cnt <= '0;
               seg_mag   <= (seg_mag == SEG_E) ? SEG_BLANK : SEG_E;
            end else begin
               blink_cnt <= blink_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_result_decoder.sv
// Directed bench for alu_result_decoder with a scoreboard: an expected
// display word is queued on every accepted handshake and compared when
// disp_valid pulses.
module tb_alu_result_decoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_res;
   logic       in_overflow;
   logic       sign;
   logic [3:0] mag;
   logic       err;
   logic       disp_valid;
   logic [7:0] seg_sign;
   logic [7:0] seg_mag;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   logic prev_dv = 1'b0;

   typedef struct {
      logic       s;
      logic [3:0] m;
      logic       e;
      logic [7:0] ss;
      logic [7:0] sm;
   } exp_t;

   exp_t q[$];

   alu_result_decoder #(.HOLD_CYCLES(4), .BLINK_HALF(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_res(in_res), .in_overflow(in_overflow), .sign(sign), .mag(mag),
      .err(err), .disp_valid(disp_valid), .seg_sign(seg_sign), .seg_mag(seg_mag)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t model(input logic [3:0] r, input logic o);
      logic [7:0] tbl [9];
      exp_t x;
      int v;
      tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80};
      v = (r >= 4'd8) ? int'(r) - 16 : int'(r);
      x.s  = (v < 0);
      x.m  = (v < 0) ? 4'(-v) : 4'(v);
      x.e  = o;
      x.ss = (!o && v < 0) ? 8'hBF : 8'hFF;
      x.sm = o ? 8'h86 : tbl[(v < 0) ? -v : v];
      return x;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Scoreboard: push on handshake, pop on disp_valid.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (in_valid && in_ready) q.push_back(model(in_res, in_overflow));
         if (disp_valid === 1'b1) begin
            chk("dv_single_pulse", {7'd0, prev_dv}, 8'd0);
            if (q.size() == 0) begin
               chk("pop_empty", 8'd1, 8'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("sb_sign", {7'd0, sign}, {7'd0, e.s});
               chk("sb_mag", {4'd0, mag}, {4'd0, e.m});
               chk("sb_err", {7'd0, err}, {7'd0, e.e});
               chk("sb_seg_sign", seg_sign, e.ss);
               chk("sb_seg_mag", seg_mag, e.sm);
            end
         end
      end
      prev_dv <= (disp_valid === 1'b1);
   end

   // Drive one result, wait for acceptance, then check the one-cycle latency.
   task automatic send(input logic [3:0] r, input logic o);
      bit ok;
      ok = 0;
      @(posedge clk); #2;
      in_valid = 1'b1; in_res = r; in_overflow = o;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1; break; end
      end
      chk("accept_timeout", {7'd0, ok}, 8'd1);
      @(posedge clk); #2;
      in_valid = 1'b0;
      @(negedge clk);
      chk("lat_ready_low", {7'd0, in_ready}, 8'd0);
      chk("lat_dv_early", {7'd0, disp_valid}, 8'd0);
      @(negedge clk);
      chk("lat_dv", {7'd0, disp_valid}, 8'd1);
   endtask

   initial begin
      int n, t0, t1;
      rst_n = 1'b0; in_valid = 1'b0; in_res = 4'd0; in_overflow = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", {7'd0, in_ready}, 8'd1);
      chk("rst_seg_sign", seg_sign, 8'hFF);
      chk("rst_seg_mag", seg_mag, 8'hC0);
      chk("rst_dv", {7'd0, disp_valid}, 8'd0);
      chk("rst_sign_mag_err", {3'd0, sign, mag}, 8'd0);

      // -3
      send(4'b1101, 1'b0);
      chk("neg3_seg_sign", seg_sign, 8'hBF);
      chk("neg3_seg_mag", seg_mag, 8'hB0);
      // -8 is legal, not an error
      send(4'b1000, 1'b0);
      chk("neg8_mag", {4'd0, mag}, 8'd8);
      chk("neg8_seg_mag", seg_mag, 8'h80);
      chk("neg8_err", {7'd0, err}, 8'd0);
      // zero shows a blank sign
      send(4'b0000, 1'b0);
      chk("zero_seg_sign", seg_sign, 8'hFF);
      chk("zero_seg_mag", seg_mag, 8'hC0);
      send(4'b0110, 1'b0);

      // Overflow blink: 86 for 8 cycles, FF for 8, then 86, into IDLE.
      send(4'b0111, 1'b1);
      for (int i = 0; i < 17; i++) begin
         if (i > 0) @(negedge clk);
         chk($sformatf("blink_%0d", i), seg_mag, (i < 8 || i == 16) ? 8'h86 : 8'hFF);
         chk("blink_seg_sign", seg_sign, 8'hFF);
      end
      chk("blink_idle_ready", {7'd0, in_ready}, 8'd1);

      // Handshake: hold in_valid with 2 then 5; changes while busy ignored.
      @(posedge clk); #2;
      in_valid = 1'b1; in_res = 4'd2; in_overflow = 1'b0;
      @(negedge clk);
      chk("hs_ready0", {7'd0, in_ready}, 8'd1);
      t0 = cyc;
      @(posedge clk); #2;
      in_res = 4'd9; in_overflow = 1'b1;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n == 3) in_res = 4'd5;
         if (n == 3) in_overflow = 1'b0;
      end
      chk("hs_busy_cycles", 8'(n), 8'd5);
      t1 = cyc;
      chk("hs_spacing", 8'(t1 - t0), 8'd6);
      @(posedge clk); #2;
      in_valid = 1'b0;
      repeat (8) @(negedge clk);

      // Reset during SHOW.
      send(4'b0110, 1'b0);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", {7'd0, in_ready}, 8'd1);
      chk("mid_rst_seg_sign", seg_sign, 8'hFF);
      chk("mid_rst_seg_mag", seg_mag, 8'hC0);
      chk("mid_rst_sign_mag", {3'd0, sign, mag}, 8'd0);
      chk("mid_rst_dv", {7'd0, disp_valid}, 8'd0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      in_valid = 1'b1; in_res = 4'b1100; in_overflow = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", {7'd0, in_ready}, 8'd1);
      @(posedge clk); #2;
      in_valid = 1'b0;
      @(negedge clk);
      chk("post_rst_capture", {7'd0, in_ready}, 8'd0);
      @(negedge clk);
      chk("post_rst_dv", {7'd0, disp_valid}, 8'd1);
      chk("post_rst_seg_mag", seg_mag, 8'h99);

      repeat (10) @(negedge clk);
      chk("sb_drained", 8'(q.size()), 8'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_result_decoder.md
# alu_result_decoder

Receives a 4-bit two's-complement result and overflow flag from the ALU subtract/add datapath over a valid/ready handshake, and converts it back to sign-magnitude: a sign bit plus a 4-bit magnitude from 0 to 8. It drives two active-low seven-segment digits on the board: a sign digit and a magnitude digit. Each accepted result is held on the display for a minimum time. On overflow the display shows a blinking error glyph instead of the number. The block sits between the ALU output and the board display pins.

## Interface
Parameters:
- HOLD_CYCLES, 4: minimum cycles spent in SHOW before the next result is accepted (≥1).
- BLINK_HALF, 8: half-period of the error blink, in cycles (≥1).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_res/in_overflow are valid.
- in_ready  out  1  block can accept a result.
- in_res  in  4  two's-complement ALU result.
- in_overflow  in  1  ALU overflow flag.
- sign  out  1  registered sign bit (1 = negative).
- mag  out  4  registered magnitude, 0–8.
- err  out  1  registered copy of the captured overflow.
- disp_valid  out  1  one-cycle pulse when new outputs land.
- seg_sign  out  8  active-low {dp,g,f,e,d,c,b,a} for the sign digit.
- seg_mag  out  8  active-low {dp,g,f,e,d,c,b,a} for the magnitude digit.

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - CONV: in_ready=0.
  - SHOW: in_ready=0.
- IDLE→CONV when in_valid&&in_ready; in_res and in_overflow are captured into internal registers.
- CONV→SHOW always, after 1 cycle; sign/mag/err/seg_* are loaded and disp_valid=1 for this one cycle.
- SHOW: the hold counter counts HOLD_CYCLES cycles, then SHOW→IDLE.
- IDLE: outputs keep their last values until the next capture.
- Conversion:
  - sign = res[3].
  - mag = res when sign=0; mag = (~res + 1) in 4-bit arithmetic when sign=1.
  - res=4'b1000 (−8) gives sign=1, mag=8. This is legal and not an error.
- Segment encoding, hex, active-low, dp always off:
  - Digits 0–8: C0, F9, A4, B0, 99, 92, 82, F8, 80.
  - minus: BF.
  - blank: FF.
  - E: 86.
- Normal case (err=0):
  - seg_sign = BF when sign=1, else FF.
  - seg_mag = digit(mag).
  - Zero always shows sign blank.
- Error case (err=1):
  - sign and mag are still loaded from the conversion.
  - seg_sign = FF.
  - seg_mag alternates between 86 and FF, starting at 86 on the CONV edge.
  - The blink counter toggles every BLINK_HALF cycles and keeps running through SHOW and IDLE until the next capture.
  - A new capture resets the blink phase.
- While in_ready=0, in_valid is ignored. There is no queueing; the upstream stage must hold its data.

## Timing
- Reset values:
  - state = IDLE, in_ready = 1.
  - sign = 0, mag = 0, err = 0, disp_valid = 0.
  - seg_sign = FF, seg_mag = C0.
  - Hold and blink counters = 0.
- Latency: capture at edge N; outputs and the disp_valid pulse are visible after edge N+1.
- in_ready falls after edge N and rises after edge N+1+HOLD_CYCLES.
- Throughput: one result per HOLD_CYCLES+2 cycles.
- Back-to-back: if in_valid is held high, the next capture happens on the first edge where in_ready=1.
- Reset asserted mid-CONV or mid-SHOW: all registers return to reset values immediately, and the captured result is discarded.
- After rst_n deasserts, the first capture is possible on the first clock edge.

## Test plan
- Reset check: hold rst_n=0, then release → in_ready=1, seg_sign=FF, seg_mag=C0, disp_valid=0.
- Negative value: capture in_res=4'b1101 (−3) → after 2 edges, sign=1, mag=3, seg_sign=BF, seg_mag=B0, one disp_valid pulse.
- Most-negative value: capture in_res=4'b1000 (−8) → sign=1, mag=8, seg_mag=80, err=0. Also capture 4'b0000 → sign=0, mag=0, seg_sign=FF, seg_mag=C0.
- Overflow blink: capture in_res=4'b0111 with in_overflow=1 and BLINK_HALF=8 → seg_sign=FF; seg_mag reads 86 for 8 cycles, FF for 8 cycles, 86 again; blinking continues in IDLE.
- Handshake: hold in_valid high with values 2 then 5 and HOLD_CYCLES=4 → in_ready low for exactly 5 cycles; the second capture occurs 6 cycles after the first; input changes while in_ready=0 are ignored.
- Reset mid-operation: pulse rst_n low during SHOW → outputs return to reset values asynchronously; the next in_valid is accepted on the first edge after release.
